point_cloud_loader: RTL and testbench
=====================================

Name: point_cloud_loader

Overview:
- Host-side writer for the four point-cloud BRAMs (x, y, z, i); it drives the second port of each dual-port BRAM.
- Packs an incoming point stream (BUS_SIZE/N points per word) into the data region, then writes the header words.
- Sets the start flag, then polls for the completion marker written by the filter engine, and reports done.

Parameters:
- N, 16, bits per coordinate/intensity sample
- BUS_SIZE, 32, BRAM data width; must equal 2*N
- BRAM_SHIFT, 2, word index to byte address shift
- MAX_POINTS, 4096, capacity of the data region in points
- TIMEOUT_CYCLES, 2**24, watchdog limit in WAIT (used only with the optional feature)

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load; accepted only in IDLE
- filter_sel  in  8  captured on start; written to the i header
- in_valid / in_ready  in/out  1 / 1  point stream handshake
- in_x, in_y, in_z, in_i  in  N each  point sample
- in_last  in  1  final point of the cloud
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the completion marker is seen
- overflow  out  1  sticky per run; set when points beyond MAX_POINTS were dropped
- point_count  out  32  number of points stored in the current or last run
- timeout_err  out  1  watchdog expiry; tied 0 when the feature is absent
- addr_x, addr_y, addr_z, addr_i  out  32 each  byte address (word << BRAM_SHIFT)
- write_in_x, write_in_y, write_in_z, write_in_i  out  BUS_SIZE each  write data
- read_out_x, read_out_y, read_out_z, read_out_i  in  BUS_SIZE each  read data, 1-cycle latency
- en_x, en_y, en_z, en_i  out  1 each  port enable
- rst_x, rst_y, rst_z, rst_i  out  1 each  held 0
- we_x, we_y, we_z, we_i  out  4 each  byte write enables

Behaviour:
- All outputs are registered. On reset, every output is 0, the state is IDLE, and the counters and pack register are cleared. Reset mid-operation aborts immediately and leaves BRAM contents untouched.
- Memory map:
  - word 0 is the header: x holds point count (32b), i holds {24'b0, filter_sel}, y holds the start flag (nonzero means go), z holds the done marker.
  - word 1 is reserved and never written.
  - point k goes to word 2+k/2, lane k%2; lane 0 is bits [N-1:0].
- State flow: IDLE -> LOAD -> (FLUSH) -> HDR -> START -> WAIT -> DONE -> IDLE.
- IDLE:
  - in_ready = 0.
  - On start: capture filter_sel, clear point_count and overflow, go to LOAD.
- LOAD:
  - in_ready = 1 every cycle, so there is no backpressure.
  - Each accepted beat with count < MAX_POINTS fills the current lane.
  - When lane 1 fills, the next cycle writes the full word to all four BRAMs (we = 4'hF) at word 2+count/2.
  - Beats at or beyond MAX_POINTS are accepted and dropped, and overflow is set.
  - On an accepted in_last beat:
    - odd stored count -> FLUSH;
    - otherwise -> HDR.
- FLUSH:
  - Writes the pending word with lane 1 zeroed, we = 4'hF.
  - Goes to HDR.
- HDR, in one cycle:
  - x0 = point_count;
  - i0 = filter_sel;
  - z0 = 0, which clears any stale marker.
  - y is not written in this cycle.
- START:
  - Writes y0 = 1.
  - Must be at least one cycle after HDR so the engine never sees start before the header is valid.
- WAIT:
  - Writes nothing; en_z = 1, addr_z = 0.
  - read_out_z is ignored on the first WAIT cycle because of read latency.
  - Afterwards, read_out_z == 32'h0000_0FFF -> DONE.
- DONE: pulse done for 1 cycle, then IDLE. point_count and overflow hold until the next start.
- Timing: the write for a completed pair is issued 1 cycle after the beat that completes it. we_* return to 0 in any cycle without a write.
- Boundary cases:
  - start while busy is ignored.
  - in_valid outside LOAD is not accepted.
  - A single-point cloud takes the LOAD -> FLUSH -> HDR path.
  - point_count never exceeds MAX_POINTS.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - a 32-bit counter runs in WAIT;
  - reaching TIMEOUT_CYCLES sets timeout_err (sticky until the next start), writes y0 = 0 and returns to IDLE without pulsing done.
- Undefined: WAIT is unbounded and timeout_err is constant 0.

Decomposition:
- Package loader_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, HDR, START, WAIT, DONE);
  - HDR_WORD = 0 and DATA_BASE_WORD = 2;
  - DONE_MARKER = 32'h0000_0FFF and START_FLAG = 32'h1.
- Sub-module lane_packer:
  - accumulates N-bit samples into BUS_SIZE words for all four channels;
  - outputs word_valid, word_index and a flush/zero-pad control.

Test Plan:
1. start, filter_sel=8'h03, 4 points with in_last on point 3 -> data words 2,3 written with x = {p1,p0}, {p3,p2}; x0=4, i0=3, z0=0; y0=1 written the cycle after HDR.
2. 3 points -> FLUSH writes word 3 = {16'h0, p2}; x0=3.
3. MAX_POINTS=4, 6 points -> only words 2,3 written; point_count=4; overflow=1.
4. After START the bench model clears y0, then writes z0=32'h0FFF 10 cycles later -> done pulses exactly once, busy falls, state returns to IDLE.
5. reset asserted mid-LOAD after 2 points -> all outputs 0 in the same cycle; a new start with 2 points completes normally.
6. LOADER_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, z0 never set -> timeout_err=1, y0 written 0, no done pulse.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared state encoding and memory-map constants for the point-cloud BRAM loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    HDR   = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } loader_state_t;

  localparam logic [31:0] HDR_WORD       = 32'd0;
  localparam logic [31:0] DATA_BASE_WORD = 32'd2;
  localparam logic [31:0] DONE_MARKER    = 32'h0000_0FFF;
  localparam logic [31:0] START_FLAG     = 32'h0000_0001;

  function automatic logic [31:0] word_addr(input logic [31:0] word, input int unsigned shift);
    return word << shift;
  endfunction

endpackage

// File: rtl/point_cloud_loader_lane_packer.sv
// Pairs consecutive N-bit samples of x/y/z/i into BUS_SIZE-bit words; lane 0 sits in the low half.
module lane_packer
  import loader_pkg::*;
#(
  parameter int N        = 16,
  parameter int BUS_SIZE = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                push,
  input  logic                flush,
  input  logic [N-1:0]        in_x,
  input  logic [N-1:0]        in_y,
  input  logic [N-1:0]        in_z,
  input  logic [N-1:0]        in_i,
  output logic                word_valid,
  output logic [31:0]         word_index,
  output logic                needs_flush,
  output logic [BUS_SIZE-1:0] word_x,
  output logic [BUS_SIZE-1:0] word_y,
  output logic [BUS_SIZE-1:0] word_z,
  output logic [BUS_SIZE-1:0] word_i
);

  logic [N-1:0] held_x, held_y, held_z, held_i;
  logic         lane;
  logic [31:0]  words;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_x <= '0;
      held_y <= '0;
      held_z <= '0;
      held_i <= '0;
      lane   <= 1'b0;
      words  <= '0;
    end else if (clear) begin
      held_x <= '0;
      held_y <= '0;
      held_z <= '0;
      held_i <= '0;
      lane   <= 1'b0;
      words  <= '0;
    end else if (push) begin
      if (!lane) begin
        held_x <= in_x;
        held_y <= in_y;
        held_z <= in_z;
        held_i <= in_i;
        lane   <= 1'b1;
      end else begin
        lane  <= 1'b0;
        words <= words + 32'd1;
      end
    end else if (flush && lane) begin
      lane  <= 1'b0;
      words <= words + 32'd1;
    end
  end

  // A flush emits the held lane-0 samples with the upper lane zero-padded.
  assign word_valid  = (push || flush) && lane;
  assign word_index  = words;
  assign needs_flush = lane;
  assign word_x = flush ? {{(BUS_SIZE-N){1'b0}}, held_x} : {in_x, held_x};
  assign word_y = flush ? {{(BUS_SIZE-N){1'b0}}, held_y} : {in_y, held_y};
  assign word_z = flush ? {{(BUS_SIZE-N){1'b0}}, held_z} : {in_z, held_z};
  assign word_i = flush ? {{(BUS_SIZE-N){1'b0}}, held_i} : {in_i, held_i};

endmodule

// File: rtl/point_cloud_loader.sv
// Host-side writer for the x/y/z/i point-cloud BRAMs: packs points, writes header, starts and polls the engine.
// Optional watchdog in WAIT enabled by defining LOADER_TIMEOUT_EN.
module point_cloud_loader
  import loader_pkg::*;
#(
  parameter int N              = 16,
  parameter int BUS_SIZE       = 32,
  parameter int BRAM_SHIFT     = 2,
  parameter int MAX_POINTS     = 4096,
  parameter int TIMEOUT_CYCLES = 2**24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          filter_sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_x,
  input  logic [N-1:0]        in_y,
  input  logic [N-1:0]        in_z,
  input  logic [N-1:0]        in_i,
  input  logic                in_last,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [31:0]         point_count,
  output logic                timeout_err,
  output logic [31:0]         addr_x,
  output logic [31:0]         addr_y,
  output logic [31:0]         addr_z,
  output logic [31:0]         addr_i,
  output logic [BUS_SIZE-1:0] write_in_x,
  output logic [BUS_SIZE-1:0] write_in_y,
  output logic [BUS_SIZE-1:0] write_in_z,
  output logic [BUS_SIZE-1:0] write_in_i,
  input  logic [BUS_SIZE-1:0] read_out_x,
  input  logic [BUS_SIZE-1:0] read_out_y,
  input  logic [BUS_SIZE-1:0] read_out_z,
  input  logic [BUS_SIZE-1:0] read_out_i,
  output logic                en_x,
  output logic                en_y,
  output logic                en_z,
  output logic                en_i,
  output logic                rst_x,
  output logic                rst_y,
  output logic                rst_z,
  output logic                rst_i,
  output logic [3:0]          we_x,
  output logic [3:0]          we_y,
  output logic [3:0]          we_z,
  output logic [3:0]          we_i
);

  if (BUS_SIZE != 2 * N) begin : g_bus_width_check
    $error("point_cloud_loader: BUS_SIZE must equal 2*N");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("point_cloud_loader: TIMEOUT_CYCLES must be positive");
  end

  loader_state_t state, next_state;
  logic [7:0]    filter_q;
  logic          wait_armed;
  logic          accept, store, marker_seen, timed_out;
  logic [31:0]   count_next;

  logic                pk_valid, pk_pending;
  logic [31:0]         pk_index;
  logic [BUS_SIZE-1:0] pk_x, pk_y, pk_z, pk_i;

  logic unused_read_ports;
  assign unused_read_ports = ^{read_out_x, read_out_y, read_out_i, pk_pending};

  assign accept      = (state == LOAD) && in_valid;
  assign store       = accept && (point_count < 32'(MAX_POINTS));
  assign count_next  = point_count + {31'b0, store};
  assign marker_seen = (state == WAIT) && wait_armed && (read_out_z == DONE_MARKER);

  assign rst_x = 1'b0;
  assign rst_y = 1'b0;
  assign rst_z = 1'b0;
  assign rst_i = 1'b0;

  lane_packer #(.N(N), .BUS_SIZE(BUS_SIZE)) u_packer (
    .clock       (clock),
    .reset       (reset),
    .clear       ((state == IDLE) && start),
    .push        (store),
    .flush       (state == FLUSH),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_z        (in_z),
    .in_i        (in_i),
    .word_valid  (pk_valid),
    .word_index  (pk_index),
    .needs_flush (pk_pending),
    .word_x      (pk_x),
    .word_y      (pk_y),
    .word_z      (pk_z),
    .word_i      (pk_i)
  );

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        timeout_q;
  assign timed_out   = (state == WAIT) && (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : 32'd0;
      if ((state == IDLE) && start) timeout_q <= 1'b0;
      else if (timed_out && !marker_seen) timeout_q <= 1'b1;
    end
  end
`else
  assign timed_out   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // An odd stored count leaves a half-filled word that FLUSH must write out.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD:    if (accept && in_last) next_state = count_next[0] ? FLUSH : HDR;
      FLUSH:   next_state = HDR;
      HDR:     next_state = START;
      START:   next_state = WAIT;
      WAIT:    if (marker_seen) next_state = DONE;
               else if (timed_out) next_state = IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Port actions decided by the current state appear on the BRAM pins one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      filter_q    <= '0;
      wait_armed  <= 1'b0;
      point_count <= '0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b0;
      done        <= 1'b0;
      {addr_x, addr_y, addr_z, addr_i} <= '0;
      {write_in_x, write_in_y, write_in_z, write_in_i} <= '0;
      {en_x, en_y, en_z, en_i} <= '0;
      {we_x, we_y, we_z, we_i} <= '0;
    end else begin
      state      <= next_state;
      busy       <= (next_state != IDLE);
      in_ready   <= (next_state == LOAD);
      done       <= (next_state == DONE);
      wait_armed <= (state == WAIT);
      {en_x, en_y, en_z, en_i} <= '0;
      {we_x, we_y, we_z, we_i} <= '0;

      if (((state == LOAD) || (state == FLUSH)) && pk_valid) begin
        addr_x <= word_addr(DATA_BASE_WORD + pk_index, BRAM_SHIFT);
        addr_y <= word_addr(DATA_BASE_WORD + pk_index, BRAM_SHIFT);
        addr_z <= word_addr(DATA_BASE_WORD + pk_index, BRAM_SHIFT);
        addr_i <= word_addr(DATA_BASE_WORD + pk_index, BRAM_SHIFT);
        write_in_x <= pk_x;
        write_in_y <= pk_y;
        write_in_z <= pk_z;
        write_in_i <= pk_i;
        {en_x, en_y, en_z, en_i} <= 4'hF;
        {we_x, we_y, we_z, we_i} <= 16'hFFFF;
      end

      case (state)
        IDLE: if (start) begin
          filter_q    <= filter_sel;
          point_count <= '0;
          overflow    <= 1'b0;
        end
        LOAD: begin
          if (store) point_count <= count_next;
          if (accept && !store) overflow <= 1'b1;
        end
        HDR: begin
          addr_x     <= word_addr(HDR_WORD, BRAM_SHIFT);
          addr_i     <= word_addr(HDR_WORD, BRAM_SHIFT);
          addr_z     <= word_addr(HDR_WORD, BRAM_SHIFT);
          write_in_x <= point_count;
          write_in_i <= {24'b0, filter_q};
          write_in_z <= '0;
          {en_x, en_i, en_z} <= 3'b111;
          we_x <= 4'hF;
          we_i <= 4'hF;
          we_z <= 4'hF;
        end
        START: begin
          // The z read is launched here so read data is valid from the second WAIT cycle.
          addr_y     <= word_addr(HDR_WORD, BRAM_SHIFT);
          write_in_y <= START_FLAG;
          en_y       <= 1'b1;
          we_y       <= 4'hF;
          addr_z     <= word_addr(HDR_WORD, BRAM_SHIFT);
          en_z       <= 1'b1;
        end
        WAIT: begin
          addr_z <= word_addr(HDR_WORD, BRAM_SHIFT);
          en_z   <= 1'b1;
          if (timed_out && !marker_seen) begin
            addr_y     <= word_addr(HDR_WORD, BRAM_SHIFT);
            write_in_y <= '0;
            en_y       <= 1'b1;
            we_y       <= 4'hF;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_point_cloud_loader.sv
// Self-checking bench for point_cloud_loader: BRAM and filter-engine model plus a point-level reference.
`timescale 1ns/1ps
module tb_point_cloud_loader;

  localparam int N    = 16;
  localparam int BUS  = 32;
  localparam int MAXP = 4;
  localparam int TMO  = 100;
  localparam int MEMW = 16;
  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [7:0] filter_sel = 8'h00;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [N-1:0] in_x = '0, in_y = '0, in_z = '0, in_i = '0;

  logic in_ready, busy, done, overflow, timeout_err;
  logic [31:0] point_count, addr_x, addr_y, addr_z, addr_i;
  logic [BUS-1:0] write_in_x, write_in_y, write_in_z, write_in_i;
  logic [BUS-1:0] read_out_x = '0, read_out_y = '0, read_out_z = '0, read_out_i = '0;
  logic en_x, en_y, en_z, en_i, rst_x, rst_y, rst_z, rst_i;
  logic [3:0] we_x, we_y, we_z, we_i;

  int checks = 0;
  int failures = 0;

  point_cloud_loader #(.N(N), .BUS_SIZE(BUS), .BRAM_SHIFT(2), .MAX_POINTS(MAXP),
                       .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .filter_sel(filter_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_i(in_i), .in_last(in_last),
    .busy(busy), .done(done), .overflow(overflow), .point_count(point_count),
    .timeout_err(timeout_err),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z), .addr_i(addr_i),
    .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z), .write_in_i(write_in_i),
    .read_out_x(read_out_x), .read_out_y(read_out_y), .read_out_z(read_out_z), .read_out_i(read_out_i),
    .en_x(en_x), .en_y(en_y), .en_z(en_z), .en_i(en_i),
    .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z), .rst_i(rst_i),
    .we_x(we_x), .we_y(we_y), .we_z(we_z), .we_i(we_i)
  );

  always #5 clock = ~clock;

  // BRAM contents and the filter engine's side of the header.
  logic [31:0] mem_x [MEMW];
  logic [31:0] mem_y [MEMW];
  logic [31:0] mem_z [MEMW];
  logic [31:0] mem_i [MEMW];
  logic fill_req = 1'b0;
  logic engine_on = 1'b1;
  int eng_cnt = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) == 32'd1) || ((a >> 2) >= 32'(2 + MAXP / 2));
  endfunction

  always @(posedge clock) begin
    if (fill_req) begin
      for (int w = 0; w < MEMW; w++) begin
        mem_x[w] <= SENTINEL;
        mem_y[w] <= SENTINEL;
        mem_z[w] <= SENTINEL;
        mem_i[w] <= SENTINEL;
      end
      eng_cnt <= 0;
    end else begin
      if (en_x) begin
        if (we_x != 4'h0) mem_x[widx(addr_x)] <= merge(mem_x[widx(addr_x)], write_in_x, we_x);
        read_out_x <= mem_x[widx(addr_x)];
      end
      if (en_y) begin
        if (we_y != 4'h0) mem_y[widx(addr_y)] <= merge(mem_y[widx(addr_y)], write_in_y, we_y);
        read_out_y <= mem_y[widx(addr_y)];
      end
      if (en_z) begin
        if (we_z != 4'h0) mem_z[widx(addr_z)] <= merge(mem_z[widx(addr_z)], write_in_z, we_z);
        read_out_z <= mem_z[widx(addr_z)];
      end
      if (en_i) begin
        if (we_i != 4'h0) mem_i[widx(addr_i)] <= merge(mem_i[widx(addr_i)], write_in_i, we_i);
        read_out_i <= mem_i[widx(addr_i)];
      end
      if (en_y && we_y == 4'hF && addr_y == 32'd0 && write_in_y == 32'd1) eng_cnt <= 11;
      else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
      if (engine_on && eng_cnt == 11) mem_y[0] <= 32'd0;
      if (engine_on && eng_cnt == 1) mem_z[0] <= 32'h0000_0FFF;
    end
  end

  // Event counters observed on the BRAM pins.
  int done_cnt = 0, data_wr_cnt = 0, bad_wr_cnt = 0, start_wr_cnt = 0, clash_cnt = 0;
  logic [31:0] x0_at_start = '0, z0_at_start = '0;

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (we_x != 4'h0 && (addr_x >> 2) >= 32'd2) data_wr_cnt++;
    if ((we_x != 4'h0 && (bad_addr(addr_x) || we_x != 4'hF)) ||
        (we_y != 4'h0 && (bad_addr(addr_y) || we_y != 4'hF)) ||
        (we_z != 4'h0 && (bad_addr(addr_z) || we_z != 4'hF)) ||
        (we_i != 4'h0 && (bad_addr(addr_i) || we_i != 4'hF))) bad_wr_cnt++;
    if (we_x != 4'h0 && addr_x == 32'd0 && we_y != 4'h0) clash_cnt++;
    if (en_y && we_y == 4'hF && addr_y == 32'd0 && write_in_y == 32'd1) begin
      start_wr_cnt++;
      x0_at_start = mem_x[0];
      z0_at_start = mem_z[0];
    end
  end

  logic [N-1:0] pts [4][16];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] mem_word(input int c, input int w);
    case (c)
      0: return mem_x[w];
      1: return mem_y[w];
      2: return mem_z[w];
      default: return mem_i[w];
    endcase
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {27'b0, busy, done, in_ready, overflow, timeout_err}, 32'd0);
    checkOutput({tag, "_count"}, point_count, 32'd0);
    checkOutput({tag, "_we"}, {16'b0, we_x, we_y, we_z, we_i}, 32'd0);
    checkOutput({tag, "_en_rst"}, {24'b0, en_x, en_y, en_z, en_i, rst_x, rst_y, rst_z, rst_i}, 32'd0);
    checkOutput({tag, "_addr"}, addr_x | addr_y | addr_z | addr_i, 32'd0);
    checkOutput({tag, "_wdata"}, write_in_x | write_in_y | write_in_z | write_in_i, 32'd0);
  endtask

  task automatic fillMemory(input bit engine);
    @(negedge clock);
    fill_req = 1'b1;
    engine_on = engine;
    @(negedge clock);
    fill_req = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input logic [7:0] fsel, input bit expect_done);
    int cnt_exp, done0, wr0, st0, bad0, clash0;
    bit ovf_exp, fell;
    logic [31:0] exp_w;
    cnt_exp = (n < MAXP) ? n : MAXP;
    ovf_exp = (n > MAXP);
    fillMemory(expect_done);
    for (int k = 0; k < n; k++)
      for (int c = 0; c < 4; c++) pts[c][k] = N'($urandom);
    done0 = done_cnt; wr0 = data_wr_cnt; st0 = start_wr_cnt; bad0 = bad_wr_cnt; clash0 = clash_cnt;

    start = 1'b1;
    filter_sel = fsel;
    @(negedge clock);
    start = 1'b0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
    checkOutput("ready_in_load", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
      in_valid = 1'b1;
      in_x = pts[0][k]; in_y = pts[1][k]; in_z = pts[2][k]; in_i = pts[3][k];
      in_last = (k == n - 1);
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last = 1'b0;

    // Stray beats and a second start while busy must be ignored.
    @(negedge clock);
    start = 1'b1; filter_sel = ~fsel;
    in_valid = 1'b1; in_last = 1'b1; in_x = 16'hBAD0;
    @(negedge clock);
    checkOutput("ready_low_after_load", {31'b0, in_ready}, 32'd0);
    start = 1'b0; filter_sel = fsel; in_valid = 1'b0; in_last = 1'b0;

    fell = 1'b0;
    for (int c = 0; c < 400 && !fell; c++) begin
      @(negedge clock);
      if (!busy) fell = 1'b1;
    end
    checkOutput("busy_falls_in_time", {31'b0, fell}, 32'd1);
    repeat (3) @(negedge clock);
    #1;
    checkOutput("stays_idle", {31'b0, busy}, 32'd0);
    checkOutput("point_count", point_count, 32'(cnt_exp));
    checkOutput("overflow", {31'b0, overflow}, {31'b0, ovf_exp});
    checkOutput("done_pulses", 32'(done_cnt - done0), expect_done ? 32'd1 : 32'd0);
    checkOutput("timeout_err", {31'b0, timeout_err}, {31'b0, !expect_done});
    checkOutput("start_flag_writes", 32'(start_wr_cnt - st0), 32'd1);
    checkOutput("x0_before_start", x0_at_start, 32'(cnt_exp));
    checkOutput("z0_before_start", z0_at_start, 32'd0);
    checkOutput("hdr_y_same_cycle", 32'(clash_cnt - clash0), 32'd0);
    checkOutput("bad_writes", 32'(bad_wr_cnt - bad0), 32'd0);
    checkOutput("data_writes", 32'(data_wr_cnt - wr0), 32'((cnt_exp + 1) / 2));
    checkOutput("hdr_x0", mem_x[0], 32'(cnt_exp));
    checkOutput("hdr_i0", mem_i[0], {24'b0, fsel});
    checkOutput("hdr_y0", mem_y[0], 32'd0);
    checkOutput("hdr_z0", mem_z[0], expect_done ? 32'h0000_0FFF : 32'd0);
    checkOutput("reserved_word1", mem_x[1] ^ mem_y[1] ^ mem_z[1] ^ mem_i[1], 32'd0);
    for (int w = 0; w < MAXP / 2; w++)
      for (int c = 0; c < 4; c++) begin
        if (2 * w >= cnt_exp) exp_w = SENTINEL;
        else if (2 * w + 1 >= cnt_exp) exp_w = {16'h0, pts[c][2*w]};
        else exp_w = {pts[c][2*w+1], pts[c][2*w]};
        checkOutput($sformatf("data_w%0d_ch%0d", w + 2, c), mem_word(c, w + 2), exp_w);
      end
  endtask

  initial begin
    #12;
    checkAllZero("reset_state");
    @(negedge clock);
    reset = 1'b0;

    $display("[TB] four points, filter 3");
    applyStimulus(4, 8'h03, 1'b1);
    $display("[TB] three points, flush path");
    applyStimulus(3, 8'h11, 1'b1);
    $display("[TB] six points, overflow");
    applyStimulus(6, 8'hA5, 1'b1);
    $display("[TB] single point");
    applyStimulus(1, 8'h7E, 1'b1);

    $display("[TB] reset during load");
    fillMemory(1'b1);
    start = 1'b1; filter_sel = 8'h5A;
    @(negedge clock);
    start = 1'b0;
    in_valid = 1'b1; in_x = 16'h1111; in_y = 16'h2222; in_z = 16'h3333; in_i = 16'h4444;
    @(negedge clock);
    in_x = 16'h5555;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    checkOutput("pair_write_issued", {28'b0, we_x}, 32'hF);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("mid_load_reset");
    @(posedge clock);
    #1;
    checkOutput("word2_untouched", mem_x[2], SENTINEL);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(2, 8'h42, 1'b1);

`ifdef LOADER_TIMEOUT_EN
    $display("[TB] watchdog expiry");
    applyStimulus(3, 8'h0C, 1'b0);
`endif

    for (int r = 0; r < 4; r++) begin
      $display("[TB] random cloud %0d", r);
      applyStimulus($urandom_range(1, 7), 8'($urandom), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
